// File: rtl/store_buffer_if.sv
// Store-buffer port bundle: datapath store/load side, memory-port side and
// occupancy status. The buffer uses the slave view; the datapath (or a
// bench standing in for it) uses the master view.
interface store_buffer_if #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    // store path
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          st_ready;

    // load lookup
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic          ld_hit;
    logic [DW-1:0] ld_fwd_data;

    // data memory port
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    // occupancy
    logic [CW-1:0] count;
    logic          empty;
    logic          full;

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr,
        input  st_ready, ld_hit, ld_fwd_data, mem_we, mem_addr, mem_wdata,
        input  count, empty, full
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr,
        output st_ready, ld_hit, ld_fwd_data, mem_we, mem_addr, mem_wdata,
        output count, empty, full
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write store buffer. Stores enter a DEPTH-entry circular FIFO in one
// cycle and drain to data memory one per cycle whenever no load owns the
// memory port. Loads see the youngest pending store to the same address
// through a combinational forwarding path.
module store_buffer #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    store_buffer_if.slave sb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Entry storage is data only; validity is implied by head and count, so
    // it needs no reset and stale contents can never be forwarded.
    logic [AW-1:0] ent_addr [DEPTH];
    logic [DW-1:0] ent_data [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] cnt;

    logic          is_empty;
    logic          is_full;
    logic          push;
    logic          pop;

    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic [PW-1:0] fwd_idx;

    // Full/empty come from the count, never from pointer equality.
    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == FULL_CNT);

    // A full buffer refuses the store even if it pops this cycle.
    assign push = sb.st_valid && !is_full;
    assign pop  = !is_empty && !sb.ld_valid;

    // Pointer and occupancy state; reset discards all pending stores.
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Capture the accepted store at the tail slot.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[tail] <= sb.st_addr;
            ent_data[tail] <= sb.st_data;
        end
    end

    // Walk valid entries oldest to youngest so the last match (youngest) wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head + PW'(k);
            if ((CW'(k) < cnt) && (ent_addr[fwd_idx] == sb.ld_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = ent_data[fwd_idx];
            end
        end
    end

    // Memory port mux: a load owns the address bus; otherwise the head drains.
    always_comb begin
        sb.mem_we    = pop;
        sb.mem_addr  = '0;
        sb.mem_wdata = '0;
        if (sb.ld_valid) begin
            sb.mem_addr = sb.ld_addr;
            if (!is_empty) begin
                sb.mem_wdata = ent_data[head];
            end
        end else if (!is_empty) begin
            sb.mem_addr  = ent_addr[head];
            sb.mem_wdata = ent_data[head];
        end
    end

    assign sb.st_ready    = !is_full;
    assign sb.ld_hit      = fwd_hit;
    assign sb.ld_fwd_data = fwd_data;
    assign sb.count       = cnt;
    assign sb.empty       = is_empty;
    assign sb.full        = is_full;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, single store, fill under load
// stall, youngest-match forwarding, push/pop across pointer wrap with a
// write-order scoreboard, and reset with entries pending.
module tb_store_buffer;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    int nerr = 0;
    int nchk = 0;
    int nwr  = 0;

    logic [63:0] sbq [$];
    logic [63:0] exp_ent;

    store_buffer_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) sbif ();

    store_buffer #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sbif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_st(input logic v, input logic [31:0] a, input logic [31:0] d);
        sbif.st_valid = v;
        sbif.st_addr  = a;
        sbif.st_data  = d;
    endtask

    initial begin
        rst           = 1'b1;
        sbif.ld_valid = 1'b0;
        sbif.ld_addr  = '0;
        drive_st(1'b0, 32'h0, 32'h0);

        // reset held two cycles
        for (int i = 0; i < 2; i++) begin
            cyc();
            #1;
            chk("rst_count",  64'(sbif.count),    64'd0);
            chk("rst_empty",  64'(sbif.empty),    64'd1);
            chk("rst_full",   64'(sbif.full),     64'd0);
            chk("rst_ready",  64'(sbif.st_ready), 64'd1);
            chk("rst_mem_we", 64'(sbif.mem_we),   64'd0);
            chk("rst_ld_hit", 64'(sbif.ld_hit),   64'd0);
            chk("rst_fwd",    64'(sbif.ld_fwd_data), 64'd0);
        end
        rst = 1'b0;

        // single store: addr 5, 0xDEADBEEF
        drive_st(1'b1, 32'd5, 32'hDEADBEEF);
        #1;
        chk("s1_we_before", 64'(sbif.mem_we), 64'd0);
        cyc();
        drive_st(1'b0, 32'h0, 32'h0);
        #1;
        chk("s1_we",    64'(sbif.mem_we),    64'd1);
        chk("s1_addr",  64'(sbif.mem_addr),  64'd5);
        chk("s1_wdata", 64'(sbif.mem_wdata), 64'hDEADBEEF);
        chk("s1_count", 64'(sbif.count),     64'd1);
        cyc();
        #1;
        chk("s1_empty_after", 64'(sbif.empty),     64'd1);
        chk("s1_we_after",    64'(sbif.mem_we),    64'd0);
        chk("s1_idle_addr",   64'(sbif.mem_addr),  64'd0);
        chk("s1_idle_wdata",  64'(sbif.mem_wdata), 64'd0);

        // fill under load stall: addr 1..4, data 0x1001..0x1004
        sbif.ld_valid = 1'b1;
        sbif.ld_addr  = 32'h100;
        for (int i = 1; i <= 4; i++) begin
            drive_st(1'b1, 32'(i), 32'h1000 + 32'(i));
            #1;
            chk("fill_we_stalled", 64'(sbif.mem_we), 64'd0);
            cyc();
        end
        drive_st(1'b1, 32'd9, 32'h9999);
        #1;
        chk("fill_full",   64'(sbif.full),      64'd1);
        chk("fill_ready",  64'(sbif.st_ready),  64'd0);
        chk("fill_count",  64'(sbif.count),     64'd4);
        chk("fill_maddr",  64'(sbif.mem_addr),  64'h100);
        chk("fill_mwdata", 64'(sbif.mem_wdata), 64'h1001);
        cyc();
        drive_st(1'b0, 32'h0, 32'h0);
        sbif.ld_addr = 32'd9;
        #1;
        chk("drop5_count", 64'(sbif.count),  64'd4);
        chk("drop5_hit",   64'(sbif.ld_hit), 64'd0);
        sbif.ld_addr = 32'd3;
        #1;
        chk("fill_fwd_hit",  64'(sbif.ld_hit),      64'd1);
        chk("fill_fwd_data", 64'(sbif.ld_fwd_data), 64'h1003);
        sbif.ld_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk("drain_we",    64'(sbif.mem_we),    64'd1);
            chk("drain_addr",  64'(sbif.mem_addr),  64'(i));
            chk("drain_wdata", 64'(sbif.mem_wdata), 64'h1000 + 64'(i));
            cyc();
        end
        #1;
        chk("drain_empty", 64'(sbif.empty), 64'd1);

        // forwarding youngest: addr 7 gets 0x11 then 0x22
        sbif.ld_valid = 1'b1;
        sbif.ld_addr  = 32'd7;
        drive_st(1'b1, 32'd7, 32'h11);
        #1;
        chk("fwd_same_cycle_hit", 64'(sbif.ld_hit), 64'd0);
        cyc();
        drive_st(1'b1, 32'd7, 32'h22);
        #1;
        chk("fwd_older_hit",  64'(sbif.ld_hit),      64'd1);
        chk("fwd_older_data", 64'(sbif.ld_fwd_data), 64'h11);
        cyc();
        drive_st(1'b0, 32'h0, 32'h0);
        #1;
        chk("fwd_young_hit",  64'(sbif.ld_hit),      64'd1);
        chk("fwd_young_data", 64'(sbif.ld_fwd_data), 64'h22);
        sbif.ld_addr = 32'd8;
        #1;
        chk("fwd_miss_hit",  64'(sbif.ld_hit),      64'd0);
        chk("fwd_miss_data", 64'(sbif.ld_fwd_data), 64'd0);
        sbif.ld_valid = 1'b0;
        #1;
        chk("fwd_drain0_addr",  64'(sbif.mem_addr),  64'd7);
        chk("fwd_drain0_wdata", 64'(sbif.mem_wdata), 64'h11);
        cyc();
        #1;
        chk("fwd_drain1_addr",  64'(sbif.mem_addr),  64'd7);
        chk("fwd_drain1_wdata", 64'(sbif.mem_wdata), 64'h22);
        cyc();
        #1;
        chk("fwd_empty", 64'(sbif.empty), 64'd1);

        // push/pop at count 2 across pointer wrap, 10 stores
        sbif.ld_valid = 1'b1;
        sbif.ld_addr  = 32'h300;
        for (int i = 0; i < 2; i++) begin
            drive_st(1'b1, 32'h200 + 32'(i), 32'hA000 + 32'(i));
            sbq.push_back({32'h200 + 32'(i), 32'hA000 + 32'(i)});
            cyc();
        end
        sbif.ld_valid = 1'b0;
        for (int i = 2; i < 10; i++) begin
            drive_st(1'b1, 32'h200 + 32'(i), 32'hA000 + 32'(i));
            #1;
            chk("pp_count", 64'(sbif.count),  64'd2);
            chk("pp_we",    64'(sbif.mem_we), 64'd1);
            exp_ent = sbq.pop_front();
            nwr++;
            chk("pp_sb_addr",  64'(sbif.mem_addr),  64'(exp_ent[63:32]));
            chk("pp_sb_wdata", 64'(sbif.mem_wdata), 64'(exp_ent[31:0]));
            sbq.push_back({32'h200 + 32'(i), 32'hA000 + 32'(i)});
            cyc();
        end
        drive_st(1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("pp_tail_we", 64'(sbif.mem_we), 64'd1);
            exp_ent = sbq.pop_front();
            nwr++;
            chk("pp_sb_addr",  64'(sbif.mem_addr),  64'(exp_ent[63:32]));
            chk("pp_sb_wdata", 64'(sbif.mem_wdata), 64'(exp_ent[31:0]));
            cyc();
        end
        #1;
        chk("pp_empty",  64'(sbif.empty),  64'd1);
        chk("pp_writes", 64'(nwr),         64'd10);
        chk("pp_sbq",    64'(sbq.size()),  64'd0);

        // reset with three entries pending
        sbif.ld_valid = 1'b1;
        sbif.ld_addr  = 32'h300;
        for (int i = 0; i < 3; i++) begin
            drive_st(1'b1, 32'h40 + 32'(i), 32'hB000 + 32'(i));
            cyc();
        end
        drive_st(1'b0, 32'h0, 32'h0);
        #1;
        chk("mid_count", 64'(sbif.count), 64'd3);
        rst = 1'b1;
        cyc();
        rst           = 1'b0;
        sbif.ld_valid = 1'b0;
        #1;
        chk("mid_rst_count", 64'(sbif.count),  64'd0);
        chk("mid_rst_empty", 64'(sbif.empty),  64'd1);
        chk("mid_rst_we",    64'(sbif.mem_we), 64'd0);
        sbif.ld_addr = 32'h41;
        #1;
        chk("mid_rst_hit", 64'(sbif.ld_hit),      64'd0);
        chk("mid_rst_fwd", 64'(sbif.ld_fwd_data), 64'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            chk("mid_rst_no_write", 64'(sbif.mem_we), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the datapath's store path and the data memory. Stores are accepted in one cycle into a DEPTH-entry FIFO and retired to memory one per cycle whenever the memory port is not needed by a load. Loads that hit a pending store get the youngest matching data forwarded, so the datapath always sees program-order memory contents.

## Interface
- AW, 32, address width; compared on all AW bits
- DW, 32, data width
- DEPTH, 4, number of buffer entries; power of two, at least 2
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- st_valid  in  1  datapath presents a store this cycle
- st_addr  in  AW  store word address
- st_data  in  DW  store data
- st_ready  out  1  buffer can accept a store; equals !full
- ld_valid  in  1  datapath performs a load this cycle and owns the memory port
- ld_addr  in  AW  load word address
- ld_hit  out  1  a pending entry matches ld_addr
- ld_fwd_data  out  DW  data of the youngest matching entry; 0 when !ld_hit
- mem_we  out  1  write enable to data memory
- mem_addr  out  AW  data memory address
- mem_wdata  out  DW  data memory write data
- count  out  $clog2(DEPTH)+1  number of valid entries
- empty  out  1  count == 0
- full  out  1  count == DEPTH

## Operation
- Storage: circular FIFO of {addr, data}, with head pointer (oldest), tail pointer, and count. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Push: when st_valid && st_ready, {st_addr, st_data} is written at the tail on the clock edge, and tail advances. st_valid with !st_ready is ignored; the datapath stalls and holds the store.
- Drain: mem_we = !empty && !ld_valid. When mem_we is 1, mem_addr/mem_wdata are the head entry, and head advances at the edge (pop).
- Port mux: when ld_valid is 1, mem_addr = ld_addr, mem_we = 0, and mem_wdata = head data, or 0 if empty. When ld_valid is 0 and the buffer is empty, mem_addr = 0 and mem_wdata = 0.
- Push and pop in the same cycle: count is unchanged and both pointers advance. If full, the pop proceeds but st_ready stays 0 that cycle; there is no same-cycle refill of a full buffer.
- Forwarding: combinational compare of ld_addr against every valid entry. The youngest match (closest to the tail) wins. A store pushed in the same cycle as the load is not visible to that load; the datapath must order them.
- Duplicate addresses are kept as separate entries, with no merging. Each entry drains in order.
- count, empty and full are registered state, or derived directly from registered state.

## Timing
- Reset: on the rst edge, head = tail = 0 and count = 0, so empty = 1, full = 0, st_ready = 1, mem_we = 0, ld_hit = 0, ld_fwd_data = 0. Entry contents are don't-care and are never forwarded.
- rst has priority over a push or pop in the same cycle. All pending stores are discarded; a reset mid-drain loses the undrained entries.
- Store-to-memory latency: at least 1 cycle. A store pushed at edge N is written to memory at edge N+1 at the earliest, if it is at the head and ld_valid = 0.
- Continuous loads (ld_valid = 1) stall the drain indefinitely. Stores keep filling until full, then st_ready drops.
- Forwarding is same-cycle combinational, from inputs to ld_hit/ld_fwd_data.
- Wrap-around: after DEPTH pushes, tail returns to 0. The full/empty distinction comes from count, not from pointer equality.

## Test plan
- Reset then idle: rst for 2 cycles -> count = 0, empty = 1, st_ready = 1, mem_we = 0 every cycle.
- Single store: push addr 5, data 0xDEADBEEF with ld_valid = 0 -> next cycle mem_we = 1, mem_addr = 5, mem_wdata = 0xDEADBEEF; the cycle after, empty = 1.
- Fill under load stall: hold ld_valid = 1 and push 4 stores (addr 1..4) -> full = 1, st_ready = 0, and a 5th st_valid is dropped. Release ld_valid -> drains 1, 2, 3, 4 on 4 consecutive cycles.
- Forwarding youngest: with ld_valid = 1, push addr 7 data 0x11, then addr 7 data 0x22 -> load addr 7 gives ld_hit = 1, ld_fwd_data = 0x22; load addr 8 gives ld_hit = 0, ld_fwd_data = 0.
- Simultaneous push/pop at count = 2 -> count stays 2, and order is preserved across pointer wrap over 10 stores. A scoreboard checks that the memory write sequence matches push order.
- Reset mid-operation: 3 entries pending, assert rst -> next cycle count = 0, mem_we = 0, no further memory writes.
